// File: rtl/fft_pkg.sv
// Shared definitions for the FFT twiddle path: defaults, quadrant codes, FSM states,
// and the elaboration-time quarter-wave table generator.
package fft_pkg;

  localparam int DATA_W_DEF = 18;
  localparam int FRAC_W_DEF = 16;

  localparam logic [1:0] QUAD_0 = 2'b00;
  localparam logic [1:0] QUAD_1 = 2'b01;
  localparam logic [1:0] QUAD_2 = 2'b10;
  localparam logic [1:0] QUAD_3 = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } tw_state_e;

  typedef struct packed {
    logic signed [31:0] re;
    logic signed [31:0] im;
  } twiddle_t;

  // Fixed-point working precision for the table generator, and 2*pi in that format.
  localparam int FX_F = 48;
  localparam logic signed [127:0] TWO_PI_FX = 128'sh6487ED5110B46;

  // Quarter-wave entry e of an N=2^stage table: (cos, -sin) of 2*pi*e/N, rounded to frac_w bits.
  // Taylor series in integer fixed point so the table folds to constants without real math.
  function automatic twiddle_t tw_rom_entry(input int e, input int stage, input int frac_w);
    logic signed [127:0] x, x2, s_term, c_term, s_sum, c_sum, rnd;
    twiddle_t r;
    x      = (TWO_PI_FX * 128'(e)) >>> stage;
    x2     = (x * x) >>> FX_F;
    s_term = x;
    s_sum  = x;
    c_term = 128'sd1 <<< FX_F;
    c_sum  = 128'sd1 <<< FX_F;
    for (int n = 1; n <= 12; n++) begin
      s_term = -(((s_term * x2) >>> FX_F) / 128'((2 * n) * (2 * n + 1)));
      c_term = -(((c_term * x2) >>> FX_F) / 128'((2 * n - 1) * (2 * n)));
      s_sum  = s_sum + s_term;
      c_sum  = c_sum + c_term;
    end
    rnd  = 128'sd1 <<< (FX_F - frac_w - 1);
    r.re = 32'((c_sum + rnd) >>> (FX_F - frac_w));
    r.im = -32'((s_sum + rnd) >>> (FX_F - frac_w));
    return r;
  endfunction

endpackage

// File: rtl/fft_tw_rom.sv
// Quarter-wave twiddle ROM with a registered, enable-gated read port.
// Contents are generated at elaboration from the same rounding rule as the offline table.
module fft_tw_rom
  import fft_pkg::*;
#(
  parameter int TW_STAGE = 7,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF
) (
  input  logic                clk,
  input  logic                en_i,
  input  logic [TW_STAGE-3:0] addr_i,
  output logic [DATA_W-1:0]   re_o,
  output logic [DATA_W-1:0]   im_o
);

  localparam int DEPTH = 1 << (TW_STAGE - 2);

  logic [2*DATA_W-1:0] table_w [DEPTH];
  logic [DATA_W-1:0]   re_q;
  logic [DATA_W-1:0]   im_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_entry
    localparam twiddle_t ENT = tw_rom_entry(g, TW_STAGE, FRAC_W);
    assign table_w[g] = {ENT.re[DATA_W-1:0], ENT.im[DATA_W-1:0]};
  end

  // Read only when the pipe advances so stalled data stays put.
  always_ff @(posedge clk) begin
    if (en_i) begin
      {re_q, im_q} <= table_w[addr_i];
    end
  end

  assign re_o = re_q;
  assign im_o = im_q;

endmodule

// File: rtl/fft_twiddle_gen.sv
// Pipelined twiddle sequencer: S0 index counter, S1 quarter-wave ROM read, S2 rotate/conjugate.
// Stream handshake: a beat transfers on a rising edge where o_valid & o_ready; the whole pipe moves when !o_valid | o_ready.
module fft_twiddle_gen
  import fft_pkg::*;
#(
  parameter int TW_STAGE = 7,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int FRAC_W   = FRAC_W_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [$clog2(TW_STAGE)-1:0] stride_log2,
  input  logic [TW_STAGE:0]           count,
  input  logic                        inverse,
  output logic                        busy,
  output logic                        o_valid,
  input  logic                        o_ready,
  output logic [TW_STAGE-1:0]         o_idx,
  output logic [DATA_W-1:0]           o_re,
  output logic [DATA_W-1:0]           o_im,
  output logic                        o_last
);

  localparam int SW = $clog2(TW_STAGE);
  localparam logic [TW_STAGE:0] ONE_K = (TW_STAGE + 1)'(1);

  tw_state_e             state_q;
  logic                  busy_q;
  logic [TW_STAGE:0]     k_q;
  logic [TW_STAGE:0]     count_q;
  logic [SW-1:0]         stride_q;
  logic                  inv_q;

  logic                  s0_valid_q;
  logic                  s0_last_q;
  logic [TW_STAGE-1:0]   s0_idx_q;

  logic                  s1_valid_q;
  logic                  s1_last_q;
  logic                  s1_inv_q;
  logic [TW_STAGE-1:0]   s1_idx_q;

  logic                  o_valid_q;
  logic                  o_last_q;
  logic [TW_STAGE-1:0]   o_idx_q;
  logic [DATA_W-1:0]     o_re_q;
  logic [DATA_W-1:0]     o_im_q;

  logic                  advance;
  logic                  accept_last;
  logic                  last_k;
  logic [TW_STAGE-1:0]   idx_d;
  logic [1:0]            quad;
  logic signed [DATA_W-1:0] rom_re;
  logic signed [DATA_W-1:0] rom_im;
  logic signed [DATA_W-1:0] rot_re;
  logic signed [DATA_W-1:0] rot_im;

  assign advance     = !o_valid_q || o_ready;
  assign accept_last = o_valid_q && o_ready && o_last_q;
  assign last_k      = (k_q == count_q - ONE_K);
  // Shifting within TW_STAGE bits gives the modulo-N wrap for free.
  assign idx_d       = k_q[TW_STAGE-1:0] << stride_q;

  // FSM plus S0 index stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      busy_q     <= 1'b0;
      k_q        <= '0;
      count_q    <= '0;
      stride_q   <= '0;
      inv_q      <= 1'b0;
      s0_valid_q <= 1'b0;
      s0_last_q  <= 1'b0;
      s0_idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start && (count != '0)) begin
            count_q  <= count;
            stride_q <= stride_log2;
            inv_q    <= inverse;
            k_q      <= '0;
            busy_q   <= 1'b1;
            state_q  <= RUN;
          end
        end
        RUN: begin
          if (advance) begin
            k_q <= k_q + ONE_K;
            if (last_k) state_q <= DRAIN;
          end
        end
        DRAIN: begin
          if (accept_last) begin
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase

      if (advance) begin
        s0_valid_q <= (state_q == RUN);
        s0_last_q  <= (state_q == RUN) && last_k;
        if (state_q == RUN) s0_idx_q <= idx_d;
      end
    end
  end

  fft_tw_rom #(
    .TW_STAGE (TW_STAGE),
    .DATA_W   (DATA_W),
    .FRAC_W   (FRAC_W)
  ) u_rom (
    .clk    (clk),
    .en_i   (advance),
    .addr_i (s0_idx_q[TW_STAGE-3:0]),
    .re_o   (rom_re),
    .im_o   (rom_im)
  );

  assign quad = s1_idx_q[TW_STAGE-1:TW_STAGE-2];

  // Multiply by (-j)^quad, then conjugate for the inverse transform.
  always_comb begin
    rot_re = rom_re;
    rot_im = rom_im;
    case (quad)
      QUAD_0: begin rot_re = rom_re;  rot_im = rom_im;  end
      QUAD_1: begin rot_re = rom_im;  rot_im = -rom_re; end
      QUAD_2: begin rot_re = -rom_re; rot_im = -rom_im; end
      QUAD_3: begin rot_re = -rom_im; rot_im = rom_re;  end
    endcase
    if (s1_inv_q) rot_im = -rot_im;
  end

  // S1 side-band and S2 output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      s1_inv_q   <= 1'b0;
      s1_idx_q   <= '0;
      o_valid_q  <= 1'b0;
      o_last_q   <= 1'b0;
      o_idx_q    <= '0;
      o_re_q     <= '0;
      o_im_q     <= '0;
    end else if (advance) begin
      s1_valid_q <= s0_valid_q;
      s1_last_q  <= s0_last_q;
      s1_inv_q   <= inv_q;
      s1_idx_q   <= s0_idx_q;
      o_valid_q  <= s1_valid_q;
      o_last_q   <= s1_valid_q && s1_last_q;
      if (s1_valid_q) begin
        o_idx_q <= s1_idx_q;
        o_re_q  <= rot_re;
        o_im_q  <= rot_im;
      end
    end
  end

  assign busy    = busy_q;
  assign o_valid = o_valid_q;
  assign o_last  = o_last_q;
  assign o_idx   = o_idx_q;
  assign o_re    = o_re_q;
  assign o_im    = o_im_q;

endmodule
